// File: rtl/ball_pixel_gen.sv
// Ball flight FSM and registered pixel colour generator.
// Optional previous-frame trail box enabled by defining BALL_TRAIL_EN.
module ball_pixel_gen #(
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          BALL_SIZE    = 8,
    parameter int          BALL_X0      = 40,
    parameter int          BALL_Y0      = 400,
    parameter int          GRAVITY      = 1,
    parameter int          HOOP_X_L     = 560,
    parameter int          HOOP_X_R     = 600,
    parameter int          HOOP_Y_T     = 200,
    parameter int          HOOP_Y_B     = 207,
    parameter int          SCORE_FRAMES = 60,
    parameter logic [11:0] BG_RGB       = 12'h000,
    parameter logic [11:0] BALL_RGB     = 12'hF80,
    parameter logic [11:0] HOOP_RGB     = 12'hFFF,
    parameter logic [11:0] TRAIL_RGB    = 12'h840
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        launch,
    input  logic [3:0]  launch_vx,
    input  logic [4:0]  launch_vy,
    output logic [11:0] rgb_out,
    output logic        ball_busy,
    output logic        score_pulse
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLIGHT = 2'd1;
    localparam logic [1:0] S_SCORED = 2'd2;

    localparam int CNT_W = $clog2(SCORE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_FRAMES - 1);

    localparam logic [9:0] REST_X = 10'(BALL_X0);
    localparam logic [9:0] REST_Y = 10'(BALL_Y0);

    // Signed 13-bit copies for the next-position range checks
    localparam logic signed [12:0] BSZ = 13'(BALL_SIZE);
    localparam logic signed [12:0] HAW = 13'(H_ACTIVE);
    localparam logic signed [12:0] VAW = 13'(V_ACTIVE);
    localparam logic signed [12:0] HXL = 13'(HOOP_X_L);
    localparam logic signed [12:0] HXR = 13'(HOOP_X_R);
    localparam logic signed [12:0] HYT = 13'(HOOP_Y_T);
    localparam logic signed [12:0] HYB = 13'(HOOP_Y_B);
    localparam logic signed [10:0] GRAV = 11'(GRAVITY);

    localparam logic [10:0] BSZ_M1 = 11'(BALL_SIZE - 1);
    localparam logic [9:0]  PX_L   = 10'(HOOP_X_L);
    localparam logic [9:0]  PX_R   = 10'(HOOP_X_R);
    localparam logic [9:0]  PY_T   = 10'(HOOP_Y_T);
    localparam logic [9:0]  PY_B   = 10'(HOOP_Y_B);

    logic [1:0]        state;
    logic [9:0]        ball_x;
    logic [9:0]        ball_y;
    logic [3:0]        vx;
    logic signed [10:0] vy;
    logic [CNT_W-1:0]  frame_cnt;

    logic signed [12:0] nx;
    logic signed [12:0] ny;
    logic signed [10:0] nvy;
    logic               hit;
    logic               miss;

    always_comb begin
        nx   = $signed({3'b000, ball_x}) + $signed({9'd0, vx});
        ny   = $signed({3'b000, ball_y}) - $signed({{2{vy[10]}}, vy});
        nvy  = vy - GRAV;
        hit  = nvy[10]
             && (nx <= HXR) && (nx + BSZ - 13'sd1 >= HXL)
             && (ny <= HYB) && (ny + BSZ - 13'sd1 >= HYT);
        miss = (nx + BSZ > HAW) || (ny + BSZ > VAW) || ny[12];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ball_x      <= REST_X;
            ball_y      <= REST_Y;
            vx          <= 4'd0;
            vy          <= 11'sd0;
            frame_cnt   <= '0;
            score_pulse <= 1'b0;
        end else begin
            score_pulse <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    ball_x <= REST_X;
                    ball_y <= REST_Y;
                    if (launch) begin
                        vx    <= launch_vx;
                        vy    <= $signed({6'd0, launch_vy});
                        state <= S_FLIGHT;
                    end
                end
                S_FLIGHT: begin
                    if (frame_tick) begin
                        // Scoring wins over a simultaneous miss
                        if (hit) begin
                            ball_x      <= nx[9:0];
                            ball_y      <= ny[9:0];
                            vy          <= nvy;
                            frame_cnt   <= '0;
                            score_pulse <= 1'b1;
                            state       <= S_SCORED;
                        end else if (miss) begin
                            ball_x <= REST_X;
                            ball_y <= REST_Y;
                            state  <= S_IDLE;
                        end else begin
                            ball_x <= nx[9:0];
                            ball_y <= ny[9:0];
                            vy     <= nvy;
                        end
                    end
                end
                S_SCORED: begin
                    if (frame_tick) begin
                        if (frame_cnt == CNT_LAST) begin
                            frame_cnt <= '0;
                            ball_x    <= REST_X;
                            ball_y    <= REST_Y;
                            state     <= S_IDLE;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ball_busy = (state != S_IDLE);

`ifdef BALL_TRAIL_EN
    logic [9:0] trail_x;
    logic [9:0] trail_y;

    always_ff @(posedge clk) begin
        if (reset || state != S_FLIGHT) begin
            trail_x <= REST_X;
            trail_y <= REST_Y;
        end else if (frame_tick) begin
            trail_x <= ball_x;
            trail_y <= ball_y;
        end
    end
`endif

    function automatic logic in_sq(input logic [9:0] x, input logic [9:0] y,
                                   input logic [9:0] bx, input logic [9:0] by);
        logic [10:0] xe;
        logic [10:0] ye;
        xe = {1'b0, bx} + BSZ_M1;
        ye = {1'b0, by} + BSZ_M1;
        return (x >= bx) && ({1'b0, x} <= xe)
            && (y >= by) && ({1'b0, y} <= ye);
    endfunction

    logic in_ball;
    logic in_hoop;
    logic in_trail;

    always_comb begin
        in_ball  = in_sq(pixel_x, pixel_y, ball_x, ball_y);
        in_hoop  = (pixel_x >= PX_L) && (pixel_x <= PX_R)
                && (pixel_y >= PY_T) && (pixel_y <= PY_B);
`ifdef BALL_TRAIL_EN
        in_trail = in_sq(pixel_x, pixel_y, trail_x, trail_y);
`else
        in_trail = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset)
            rgb_out <= 12'h000;
        else if (!video_on)
            rgb_out <= 12'h000;
        else if (in_ball)
            rgb_out <= BALL_RGB;
        else if (in_trail)
            rgb_out <= TRAIL_RGB;
        else if (in_hoop)
            rgb_out <= HOOP_RGB;
        else
            rgb_out <= BG_RGB;
    end

endmodule

// File: tb/tb_ball_pixel_gen.sv
// Randomized bench for ball_pixel_gen against a trajectory model.
// Directed shots cover launch, scoring, misses and reset.
module tb_ball_pixel_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        frame_tick;
    logic        launch;
    logic [3:0]  launch_vx;
    logic [4:0]  launch_vy;
    logic [11:0] rgb_out;
    logic        ball_busy;
    logic        score_pulse;

    ball_pixel_gen dut (
        .clk(clk), .reset(reset),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .frame_tick(frame_tick), .launch(launch),
        .launch_vx(launch_vx), .launch_vy(launch_vy),
        .rgb_out(rgb_out), .ball_busy(ball_busy), .score_pulse(score_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 idle, 1 flight, 2 scored
    int m_st, m_bx, m_by, m_vx, m_vy, m_cnt, m_sp, m_tx, m_ty;
    int exp_rgb;
    int sp_seen;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    function automatic bit in_sq(int x, int y, int bx, int by);
        return x >= bx && x <= bx + 7 && y >= by && y <= by + 7;
    endfunction

    function automatic int model_pix(int x, int y, bit von);
        if (!von) return 'h000;
        if (in_sq(x, y, m_bx, m_by)) return 'hF80;
`ifdef BALL_TRAIL_EN
        if (in_sq(x, y, m_tx, m_ty)) return 'h840;
`endif
        if (x >= 560 && x <= 600 && y >= 200 && y <= 207) return 'hFFF;
        return 'h000;
    endfunction

    task automatic model_step(bit rst, bit ln, int lvx, int lvy, bit tk);
        int nx, ny, nvy;
        bit hit, miss;
        if (rst) begin
            m_st = 0; m_bx = 40; m_by = 400; m_vx = 0; m_vy = 0;
            m_cnt = 0; m_sp = 0; m_tx = 40; m_ty = 400;
            return;
        end
        if (m_st != 1) begin
            m_tx = 40; m_ty = 400;
        end else if (tk) begin
            m_tx = m_bx; m_ty = m_by;
        end
        m_sp = 0;
        case (m_st)
            0: begin
                m_bx = 40; m_by = 400;
                if (ln) begin
                    m_vx = lvx; m_vy = lvy; m_st = 1;
                end
            end
            1: if (tk) begin
                nx = m_bx + m_vx;
                ny = m_by - m_vy;
                nvy = m_vy - 1;
                hit = nvy < 0 && nx <= 600 && nx + 7 >= 560
                      && ny <= 207 && ny + 7 >= 200;
                miss = nx + 8 > 640 || ny + 8 > 480 || ny < 0;
                if (hit) begin
                    m_bx = nx; m_by = ny; m_vy = nvy;
                    m_cnt = 0; m_sp = 1; m_st = 2;
                end else if (miss) begin
                    m_bx = 40; m_by = 400; m_st = 0;
                end else begin
                    m_bx = nx; m_by = ny; m_vy = nvy;
                end
            end
            default: if (tk) begin
                if (m_cnt == 59) begin
                    m_cnt = 0; m_bx = 40; m_by = 400; m_st = 0;
                end else begin
                    m_cnt++;
                end
            end
        endcase
    endtask

    task automatic step(bit rst, bit ln, int lvx, int lvy, bit tk,
                        int px, int py, bit von);
        reset      = rst;
        launch     = ln;
        launch_vx  = 4'(lvx);
        launch_vy  = 5'(lvy);
        frame_tick = tk;
        pixel_x    = 10'(px);
        pixel_y    = 10'(py);
        video_on   = von;
        @(posedge clk);
        exp_rgb = rst ? 0 : model_pix(px & 'h3FF, py & 'h3FF, von);
        model_step(rst, ln, lvx, lvy, tk);
        #1;
        sp_seen += int'(score_pulse);
        check("rgb", int'(rgb_out), exp_rgb);
        check("busy", int'(ball_busy), int'(m_st != 0));
        check("score_pulse", int'(score_pulse), m_sp);
        check("ball_x", int'(dut.ball_x), m_bx);
        check("ball_y", int'(dut.ball_y), m_by);
    endtask

    task automatic idle_cycle();
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic tick();
        step(0, 0, 0, 0, 1, 0, 0, 1);
        idle_cycle();
    endtask

    initial begin
        int px, py, mode;
        sp_seen = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_rgb", int'(rgb_out), 0);
        check("reset_busy", int'(ball_busy), 0);

        step(0, 0, 0, 0, 0, 40, 400, 1);
        check("rest_ball_pix", int'(rgb_out), 'hF80);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("origin_pix", int'(rgb_out), 'h000);
        step(0, 0, 0, 0, 0, 40, 400, 0);
        check("blank_pix", int'(rgb_out), 'h000);
        step(0, 0, 0, 0, 0, 580, 203, 1);
        check("hoop_pix", int'(rgb_out), 'hFFF);

        step(0, 1, 4, 10, 0, 0, 0, 1);
        repeat (3) tick();
        check("fl_x", int'(dut.ball_x), 52);
        check("fl_y", int'(dut.ball_y), 373);
        check("fl_vy", int'(dut.vy), 7);
        check("fl_busy", int'(ball_busy), 1);
        step(0, 1, 1, 1, 0, 0, 0, 1);
        check("relaunch_vx", int'(dut.vx), 4);
        check("relaunch_vy", int'(dut.vy), 7);

        step(1, 0, 0, 0, 1, 52, 373, 1);
        check("rst_mid_busy", int'(ball_busy), 0);
        check("rst_mid_x", int'(dut.ball_x), 40);
        check("rst_mid_rgb", int'(rgb_out), 0);
        step(0, 1, 4, 10, 1, 0, 0, 1);
        check("launch_tick_x", int'(dut.ball_x), 40);
        check("launch_tick_y", int'(dut.ball_y), 400);

        step(1, 0, 0, 0, 0, 0, 0, 1);
        sp_seen = 0;
        step(0, 1, 15, 23, 0, 0, 0, 1);
        repeat (36) tick();
        check("score_x", int'(dut.ball_x), 580);
        check("score_y", int'(dut.ball_y), 202);
        check("score_cnt", sp_seen, 1);
        repeat (59) tick();
        check("scored_hold", int'(ball_busy), 1);
        tick();
        check("scored_done", int'(ball_busy), 0);
        check("scored_rest_y", int'(dut.ball_y), 400);

        sp_seen = 0;
        step(0, 1, 15, 2, 0, 0, 0, 1);
        repeat (20) tick();
        check("miss_busy", int'(ball_busy), 0);
        check("miss_no_score", sp_seen, 0);
        check("miss_rest_x", int'(dut.ball_x), 40);

        for (int i = 0; i < 4000; i++) begin
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                px = int'($urandom_range(0, 639));
                py = int'($urandom_range(0, 479));
            end else if (mode == 3) begin
                px = int'($urandom_range(555, 605));
                py = int'($urandom_range(195, 212));
            end else begin
                px = (m_bx + int'($urandom_range(0, 11)) - 2) & 'h3FF;
                py = (m_by + int'($urandom_range(0, 11)) - 2) & 'h3FF;
            end
            step($urandom_range(0, 699) == 0,
                 $urandom_range(0, 15) == 0,
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 31)),
                 $urandom_range(0, 2) == 0,
                 px, py, $urandom_range(0, 7) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
